// File: rtl/spi_sclk_gen_if.sv
// Bundle between the SPI master FSM and the SCLK generator: burst
// configuration and control in, serial clock, status and strobes out.
interface spi_sclk_gen_if #(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned BITS_W = 6
) ();
    logic [DIV_W-1:0]  half_div;
    logic              cpol;
    logic              cpha;
    logic [BITS_W-1:0] nbits;
    logic              start;
    logic              abort;
    logic              sclk;
    logic              busy;
    logic              done;
    logic              sample_strobe;
    logic              shift_strobe;

    // Controller side: programs and launches bursts, watches status.
    modport master (
        output half_div, cpol, cpha, nbits, start, abort,
        input  sclk, busy, done, sample_strobe, shift_strobe
    );

    // Generator side.
    modport slave (
        input  half_div, cpol, cpha, nbits, start, abort,
        output sclk, busy, done, sample_strobe, shift_strobe
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator. Produces bursts of nbits SCLK cycles with a
// programmable half-period, in any CPOL/CPHA mode, plus single-cycle sample
// and shift strobes that coincide with the cycle SCLK shows each new level.
// A TAIL phase of one half-period holds SCLK idle before done is pulsed.
module spi_sclk_gen #(
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned BITS_W       = 6,
    parameter int unsigned DEFAULT_HALF = 10
) (
    input logic            clk_100mhz,
    input logic            reset_n,
    spi_sclk_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

    state_t            state;
    logic [DIV_W-1:0]  half_l;
    logic [DIV_W-1:0]  cnt;
    logic              cpol_l;
    logic              cpha_l;
    logic [BITS_W-1:0] nbits_l;
    logic [BITS_W:0]   edges;

    logic              sclk_q;
    logic              busy_q;
    logic              done_q;
    logic              sample_q;
    logic              shift_q;

    logic [DIV_W-1:0]  half_sel;
    logic              half_hit;
    logic [BITS_W:0]   edges_nxt;
    logic              last_edge;
    logic              lead_sample;

    // Decode of the programmed half-period and the next edge's properties.
    always_comb begin
        half_sel    = (bus.half_div == '0) ? DIV_W'(DEFAULT_HALF) : bus.half_div;
        half_hit    = (cnt == (half_l - DIV_W'(1)));
        edges_nxt   = edges + (BITS_W+1)'(1);
        last_edge   = (edges_nxt == {nbits_l, 1'b0});
        // Odd edge numbers are leading edges; with cpha=0 those are sampled.
        lead_sample = edges_nxt[0] ^ cpha_l;
    end

    // Burst sequencer: every output is a register updated here.
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            half_l   <= '0;
            cnt      <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            nbits_l  <= '0;
            edges    <= '0;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_q <= bus.cpol;
                    if (bus.start && !bus.abort) begin
                        half_l  <= half_sel;
                        cpol_l  <= bus.cpol;
                        cpha_l  <= bus.cpha;
                        nbits_l <= bus.nbits;
                        cnt     <= '0;
                        edges   <= '0;
                        busy_q  <= 1'b1;
                        state   <= (bus.nbits == '0) ? TAIL : RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        sclk_q <= cpol_l;
                        cnt    <= '0;
                        edges  <= '0;
                    end else if (half_hit) begin
                        cnt      <= '0;
                        sclk_q   <= ~sclk_q;
                        edges    <= edges_nxt;
                        sample_q <= lead_sample;
                        shift_q  <= ~lead_sample;
                        if (last_edge) begin
                            state <= TAIL;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                TAIL: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        sclk_q <= cpol_l;
                        cnt    <= '0;
                        edges  <= '0;
                    end else if (half_hit) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sclk          = sclk_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.sample_strobe = sample_q;
    assign bus.shift_strobe  = shift_q;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: table of directed bursts, random
// bursts, and hand sequences for abort/start races and mid-burst reset.
// Expected outputs come from a closed-form timeline of each burst.
module tb_spi_sclk_gen;
    logic clk_100mhz = 1'b0;
    logic reset_n    = 1'b0;
    int   tests = 0;
    int   fails = 0;

    spi_sclk_gen_if #(.DIV_W(8), .BITS_W(6)) bus ();

    spi_sclk_gen #(.DIV_W(8), .BITS_W(6), .DEFAULT_HALF(10)) dut (
        .clk_100mhz (clk_100mhz),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct packed {
        logic sclk;
        logic busy;
        logic done;
        logic samp;
        logic shift;
    } obs_t;

    typedef struct {
        logic [7:0] hd;
        logic       cp;
        logic       ph;
        logic [5:0] nb;
        int         ab;
        int         exp_done;
        int         exp_edges;
    } vec_t;

    task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    // Timeline of a burst whose start was sampled at t=0: edge k (1..2n) at
    // t=k*h, done at (2n+1)*h, abort sampled at t=a forces idle from t=a.
    function automatic obs_t model(input int t, input int h, input int n,
                                   input logic cpol, input logic cpha, input int a);
        obs_t o;
        int   td;
        int   k;
        logic lead;
        o      = '0;
        o.sclk = cpol;
        td     = (2 * n + 1) * h;
        if (a >= 0 && t >= a) return o;
        if (t < td) begin
            o.busy = 1'b1;
            k = t / h;
            if (k > 2 * n) k = 2 * n;
            o.sclk = cpol ^ k[0];
            if (t > 0 && (t % h) == 0 && (t / h) <= 2 * n) begin
                lead    = ((t / h) % 2) == 1;
                o.samp  = (lead != cpha);
                o.shift = (lead == cpha);
            end
        end else if (t == td) begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    // Called #1 after a clock edge with the DUT idle; returns #1 after an edge.
    task automatic run_burst(input logic [7:0] hd, input logic cp, input logic ph,
                             input logic [5:0] nb, input int abort_at, input bit scramble,
                             output int done_t, output int nedges);
        int   h;
        int   n;
        int   td;
        int   lim;
        obs_t e;
        h   = (hd == 8'd0) ? 10 : int'(hd);
        n   = int'(nb);
        td  = (2 * n + 1) * h;
        lim = (abort_at >= 0 && abort_at < td) ? abort_at : td;
        bus.half_div = hd;
        bus.cpol     = cp;
        bus.cpha     = ph;
        bus.nbits    = nb;
        bus.abort    = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk_100mhz); #1;
        bus.start = 1'b0;
        done_t    = -1;
        nedges    = 0;
        for (int t = 0; t <= td + 2; t++) begin
            e = model(t, h, n, cp, ph, abort_at);
            check("sclk",   t, 32'(bus.sclk),          32'(e.sclk));
            check("busy",   t, 32'(bus.busy),          32'(e.busy));
            check("done",   t, 32'(bus.done),          32'(e.done));
            check("sample", t, 32'(bus.sample_strobe), 32'(e.samp));
            check("shift",  t, 32'(bus.shift_strobe),  32'(e.shift));
            if (bus.done && done_t < 0) done_t = t;
            if (bus.sample_strobe || bus.shift_strobe) nedges++;
            bus.abort = (abort_at >= 0 && t + 1 == abort_at);
            if (scramble && t >= 1 && t + 1 < lim) begin
                bus.half_div = 8'($urandom_range(0, 255));
                bus.cpol     = 1'($urandom_range(0, 1));
                bus.cpha     = 1'($urandom_range(0, 1));
                bus.nbits    = 6'($urandom_range(0, 63));
                bus.start    = 1'($urandom_range(0, 1));
            end else begin
                bus.half_div = hd;
                bus.cpol     = cp;
                bus.cpha     = ph;
                bus.nbits    = nb;
                bus.start    = 1'b0;
            end
            @(posedge clk_100mhz); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   done_t;
        int   nedges;
        int   h;
        int   n;
        int   td;
        int   ab;
        int   exp_e;
        logic [7:0] hd;
        logic [5:0] nb;
        logic       cp;
        logic       ph;

        // done_t is counted from the edge that samples start, one cycle after
        // start is raised (so nbits=0, H=5 gives done 6 cycles after start).
        vecs[0] = '{8'd0,  1'b0, 1'b0, 6'd8, -1, 170, 16};
        vecs[1] = '{8'd1,  1'b1, 1'b1, 6'd4, -1,   9,  8};
        vecs[2] = '{8'd3,  1'b0, 1'b1, 6'd2, -1,  15,  4};
        vecs[3] = '{8'd5,  1'b0, 1'b0, 6'd0, -1,   5,  0};
        vecs[4] = '{8'd10, 1'b0, 1'b0, 6'd8, 35,  -1,  3};
        vecs[5] = '{8'd2,  1'b1, 1'b0, 6'd1,  6,  -1,  2};

        bus.half_div = '0;
        bus.cpol     = 1'b1;
        bus.cpha     = 1'b0;
        bus.nbits    = '0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        repeat (3) @(posedge clk_100mhz);
        #1;
        check("rst_sclk",   0, 32'(bus.sclk),          32'd0);
        check("rst_busy",   0, 32'(bus.busy),          32'd0);
        check("rst_done",   0, 32'(bus.done),          32'd0);
        check("rst_sample", 0, 32'(bus.sample_strobe), 32'd0);
        check("rst_shift",  0, 32'(bus.shift_strobe),  32'd0);
        @(negedge clk_100mhz);
        reset_n = 1'b1;
        @(posedge clk_100mhz); #1;
        check("idle_sclk_cpol", 0, 32'(bus.sclk), 32'd1);

        // Directed table; vector 4 also pulses start while busy.
        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i].hd, vecs[i].cp, vecs[i].ph, vecs[i].nb, vecs[i].ab, (i == 4),
                      done_t, nedges);
            check($sformatf("vec%0d_done_time", i), i, 32'(done_t), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_edges", i),     i, 32'(nedges), 32'(vecs[i].exp_edges));
        end

        // abort together with start in IDLE: no burst launched.
        bus.cpol  = 1'b0;
        bus.nbits = 6'd3;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk_100mhz); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_start_busy0", 0, 32'(bus.busy), 32'd0);
        @(posedge clk_100mhz); #1;
        check("abort_start_busy1", 1, 32'(bus.busy), 32'd0);

        // Reset during RUN with cpol=1 latched.
        bus.half_div = 8'd4;
        bus.cpol     = 1'b1;
        bus.cpha     = 1'b0;
        bus.nbits    = 6'd3;
        bus.start    = 1'b1;
        @(posedge clk_100mhz); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk_100mhz);
        #1;
        check("pre_rst_busy", 2, 32'(bus.busy), 32'd1);
        check("pre_rst_sclk", 2, 32'(bus.sclk), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_sclk",   0, 32'(bus.sclk),          32'd0);
        check("async_rst_busy",   0, 32'(bus.busy),          32'd0);
        check("async_rst_done",   0, 32'(bus.done),          32'd0);
        check("async_rst_sample", 0, 32'(bus.sample_strobe), 32'd0);
        check("async_rst_shift",  0, 32'(bus.shift_strobe),  32'd0);
        @(negedge clk_100mhz);
        reset_n = 1'b1;
        @(posedge clk_100mhz); #1;
        check("post_rst_sclk", 0, 32'(bus.sclk), 32'd1);
        check("post_rst_busy", 0, 32'(bus.busy), 32'd0);
        run_burst(8'd4, 1'b1, 1'b0, 6'd3, -1, 1'b0, done_t, nedges);
        check("post_rst_done_time", 0, 32'(done_t), 32'd28);
        check("post_rst_edges",     0, 32'(nedges), 32'd6);

        // Random bursts with random aborts and mid-burst input noise.
        for (int r = 0; r < 30; r++) begin
            hd = 8'($urandom_range(0, 6));
            nb = 6'($urandom_range(0, 7));
            cp = 1'($urandom_range(0, 1));
            ph = 1'($urandom_range(0, 1));
            h  = (hd == 8'd0) ? 10 : int'(hd);
            n  = int'(nb);
            td = (2 * n + 1) * h;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, td)) : -1;
            run_burst(hd, cp, ph, nb, ab, 1'b1, done_t, nedges);
            if (ab < 0) begin
                exp_e = 2 * n;
                check($sformatf("rnd%0d_done_time", r), r, 32'(done_t), 32'(td));
            end else begin
                exp_e = (ab - 1) / h;
                if (exp_e > 2 * n) exp_e = 2 * n;
                check($sformatf("rnd%0d_no_done", r), r, 32'(done_t), 32'hFFFF_FFFF);
            end
            check($sformatf("rnd%0d_edges", r), r, 32'(nedges), 32'(exp_e));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised SPI serial-clock generator. It derives SCLK from the 100 MHz system clock using a runtime-programmable half-period divisor. It supports all four CPOL/CPHA modes and produces bursts of a programmable number of bits. It emits single-cycle sample and shift strobes aligned to SCLK edges, and sits between the SPI master FSM and the SCLK pad.

Parameters:
DIV_W, 8, width of half-period divisor input
BITS_W, 6, width of burst bit-count input
DEFAULT_HALF, 10, half-period used when half_div = 0 (10 -> 5 MHz from 100 MHz)

Ports:
clk_100mhz  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous active-low reset
half_div  input  DIV_W  SCLK half-period in clk_100mhz cycles; 0 selects DEFAULT_HALF
cpol  input  1  SCLK idle level
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
nbits  input  BITS_W  bits per burst; 0 = empty burst
start  input  1  burst request, sampled in IDLE only
abort  input  1  synchronous burst cancel
sclk  output  1  serial clock
busy  output  1  burst in progress
done  output  1  one-cycle pulse at normal burst completion
sample_strobe  output  1  one-cycle pulse coincident with each sample edge
shift_strobe  output  1  one-cycle pulse coincident with each shift edge

Behaviour:
- Reset (async, reset_n=0): state IDLE; sclk=0, busy=0, done=0, strobes=0, counters=0. Reset mid-burst ends the burst immediately and produces no done.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, RUN, TAIL.
- IDLE:
  - sclk <= cpol every cycle.
  - start=1 latches H (half_div, or DEFAULT_HALF if half_div is 0), cpol, cpha and nbits.
  - If nbits != 0: go to RUN; busy=1 from the next cycle; half-period counter=0; edge counter=0.
  - If nbits == 0: go to TAIL directly.
- RUN:
  - The half-period counter increments each cycle.
  - When the counter reaches H-1, it resets to 0, sclk toggles, and the edge counter increments; these take effect in the same registered update.
  - The first edge is visible H cycles after busy rises; each later edge follows H cycles after the previous one.
  - Edges are numbered 1..2*nbits. Odd-numbered edges are leading edges; even-numbered edges are trailing edges.
  - Strobe mapping:
    - cpha=0: sample_strobe on leading edges, shift_strobe on trailing edges.
    - cpha=1: shift_strobe on leading edges, sample_strobe on trailing edges.
  - Each strobe is high in exactly the cycle sclk first shows its new level.
  - After edge 2*nbits, sclk equals the latched cpol; go to TAIL.
- TAIL:
  - Hold sclk at cpol for H cycles (minimum CS hold).
  - Then assert done for 1 cycle. busy deasserts in the same cycle. Return to IDLE.
  - With nbits=0, TAIL lasts H cycles, so done arrives H+1 cycles after start.
- Changes to half_div, cpol, cpha or nbits during a burst have no effect until the next start.
- start while busy=1 is ignored. No queueing.
- abort=1 in RUN or TAIL:
  - Next cycle: IDLE, busy=0, sclk=latched cpol, no done, no strobes.
  - abort takes priority over an edge falling in the same cycle.
  - abort in IDLE has no effect. If abort and start are both high in IDLE, abort wins and start is ignored.
- H=1 is legal: SCLK = clk/2 = 50 MHz, with strobes on consecutive cycles alternating sample/shift.
- Maximum nbits = 2^BITS_W - 1. The edge counter is BITS_W+1 bits wide and does not wrap within a burst.
- Counter widths: half-period counter is DIV_W bits; it compares against H-1 and never overflows.

Test Plan:
- Mode 0, half_div=0 (H=10), nbits=8 -> sclk idles 0 with period 20 cycles (5 MHz); 8 sample_strobes on rising edges; 8 shift_strobes on falling edges; first edge 10 cycles after busy rises; done 170 cycles after busy rises, with busy falling the same cycle.
- Mode 3 (cpol=1, cpha=1), half_div=1, nbits=4 -> sclk idles 1 and toggles every cycle; strobes on 8 consecutive cycles as shift/sample alternating; sclk=1 after edge 8; done after 1-cycle tail.
- Mode 1 (cpol=0, cpha=1), half_div=3, nbits=2 -> shift_strobe on rising edges and sample_strobe on falling edges; 4 edges at busy+3, +6, +9, +12; done at busy+15.
- nbits=0, half_div=5, start -> no sclk edges and no strobes; done exactly 6 cycles after start; busy high for 5 cycles.
- Mode 0, H=10, nbits=8, abort after 3rd edge; also start pulsed while busy -> next cycle busy=0, sclk=0, no done, no further strobes; the start during busy produces no second burst.
- reset_n driven low mid-RUN with cpol=1 latched -> sclk, busy, done and strobes are 0 asynchronously; after release, IDLE drives sclk to cpol the next cycle; a new start runs a full, correct burst.
